// File: rtl/btn_esemenykezelo.sv
// btn_esemenykezelo: press/release/long-press/auto-repeat event unit behind the button debouncer
module btn_esemenykezelo #(
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_deb,
    output logic       press,
    output logic       release_evt,
    output logic       long_press,
    output logic       repeat_evt,
    output logic       held,
    output logic [7:0] press_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} state_t;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_TICKS - 1);
    state_t      state_q, state_d;
    logic        btn_q;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        press_q, press_d, rel_q, rel_d, lp_q, lp_d, rpt_q, rpt_d;
    logic        rise, fall;
    assign rise = btn_deb & ~btn_q;
    assign fall = ~btn_deb & btn_q;
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        lp_d    = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (rise) begin
                state_d = ST_PRESSED;
                tcnt_d  = '0;
                press_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
            end
            ST_PRESSED: if (fall) begin
                state_d = ST_IDLE;
                rel_d   = 1'b1;
            end else if (en) begin
                lp_d    = tcnt_q == HOLD_LAST;
                state_d = lp_d ? ST_REPEAT : ST_PRESSED;
                tcnt_d  = lp_d ? '0 : tcnt_q + 16'd1;
            end
            ST_REPEAT: if (fall) begin
                state_d = ST_IDLE;
                rel_d   = 1'b1;
            end else if (en) begin
                rpt_d  = tcnt_q == REP_LAST;
                tcnt_d = rpt_d ? '0 : tcnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            btn_q   <= 1'b0;
            tcnt_q  <= '0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            lp_q    <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_deb;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            lp_q    <= lp_d;
            rpt_q   <= rpt_d;
        end
    end
    assign press       = press_q;
    assign release_evt = rel_q;
    assign long_press  = lp_q;
    assign repeat_evt  = rpt_q;
    assign held        = state_q != ST_IDLE;
    assign press_cnt   = cnt_q;
endmodule

// File: tb/tb_btn_esemenykezelo.sv
// tb_btn_esemenykezelo: directed checks of btn_esemenykezelo with HOLD_TICKS=4, REPEAT_TICKS=2
module tb_btn_esemenykezelo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       btn_deb = 1'b0;
    logic       press, release_evt, long_press, repeat_evt, held;
    logic [7:0] press_cnt;
    int         n_pass = 0;
    int         n_chk = 0;
    logic [4:0] seen;

    btn_esemenykezelo #(.HOLD_TICKS(4), .REPEAT_TICKS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .btn_deb(btn_deb),
        .press(press), .release_evt(release_evt), .long_press(long_press),
        .repeat_evt(repeat_evt), .held(held), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    // {press, release, long_press, repeat, held}
    function automatic logic [4:0] outs();
        return {press, release_evt, long_press, repeat_evt, held};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drive one cycle of inputs, then sample #1 after the edge
    task automatic step(input logic b, input logic e);
        btn_deb = b;
        en      = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset then idle with en every cycle
        step(0, 1);
        chk("rst_outs", 16'(outs()), 16'h0);
        chk("rst_cnt", 16'(press_cnt), 16'h0);
        rst  = 1'b1;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            seen |= outs();
        end
        chk("idle_outs", 16'(seen), 16'h0);
        chk("idle_cnt", 16'(press_cnt), 16'h0);

        // 2: short press
        step(1, 1);
        chk("short_press", 16'(outs()), 16'b10001);
        step(1, 1);
        chk("short_hold", 16'(outs()), 16'b00001);
        step(0, 1);
        chk("short_rel", 16'(outs()), 16'b01000);
        chk("short_cnt", 16'(press_cnt), 16'd1);

        // 3: long press then repeats every 2 ticks
        step(1, 1);
        chk("long_press_evt", 16'(outs()), 16'b10001);
        for (int k = 1; k < 20; k++) begin
            step(1, 1);
            chk($sformatf("long_k%0d", k), 16'(outs()),
                16'({2'b00, k == 4, (k >= 6) && (k % 2 == 0), 1'b1}));
        end
        step(0, 1);
        chk("long_rel", 16'(outs()), 16'b01000);
        chk("long_cnt", 16'(press_cnt), 16'd2);

        // 4: fall on the terminal tick wins over long_press
        step(1, 1);
        chk("prio_press", 16'(outs()), 16'b10001);
        for (int i = 0; i < 3; i++) step(1, 1);
        step(0, 1);
        chk("prio_rel", 16'(outs()), 16'b01000);
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1);
            seen |= outs();
        end
        chk("prio_after", 16'(seen), 16'h0);

        // 5: 257 presses from reset wrap the counter to 1
        rst = 1'b0;
        step(0, 0);
        rst = 1'b1;
        for (int i = 0; i < 257; i++) begin
            step(1, 0);
            step(0, 0);
            step(0, 0);
            if (i == 254) chk("wrap_255", 16'(press_cnt), 16'd255);
            if (i == 255) chk("wrap_0", 16'(press_cnt), 16'd0);
        end
        chk("wrap_1", 16'(press_cnt), 16'd1);

        // 6: reset during REPEAT with the button still held
        step(1, 1);
        for (int i = 0; i < 6; i++) step(1, 1);
        chk("rep_state", 16'(held), 16'd1);
        rst = 1'b0;
        step(1, 1);
        chk("mid_rst_outs", 16'(outs()), 16'h0);
        chk("mid_rst_cnt", 16'(press_cnt), 16'h0);
        rst = 1'b1;
        step(1, 1);
        chk("post_rst_press", 16'(outs()), 16'b10001);
        chk("post_rst_cnt", 16'(press_cnt), 16'd1);
        step(0, 1);
        chk("post_rst_rel", 16'(outs()), 16'b01000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
